// File: rtl/me_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | me_pkg : shared types and width helpers for the motion-estimation core|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package me_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RESULT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } me_sched_state_t;

  function automatic int sad_w(input int tb_length, input int pe_out_width);
    return $clog2(tb_length * tb_length) + pe_out_width;
  endfunction

  function automatic int mv_w(input int sw_length, input int tb_length);
    return $clog2((sw_length - tb_length + 1) * (sw_length - tb_length + 1));
  endfunction

  function automatic int blk_w(input int num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/me_sched_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | me_sched_timer : loadable down-counter flagging a handshake timeout  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module me_sched_timer #(
  parameter int unsigned TIMEOUT = 65535,
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Loading TIMEOUT-1 makes expired rise in the TIMEOUT-th cycle of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT - 1);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/me_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | me_sched : per-block req/ack sequencer with result port and best SAD |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module me_sched
  import me_pkg::*;
#(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  parameter int NUM_BLOCKS   = 4,
  parameter int unsigned TIMEOUT = 65535,
  localparam int SAD_W = sad_w(TB_LENGTH, PE_OUT_WIDTH),
  localparam int MV_W  = mv_w(SW_LENGTH, TB_LENGTH),
  localparam int BLK_W = blk_w(NUM_BLOCKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SAD_W-1:0] threshold,
  output logic             me_req,
  output logic [SAD_W-1:0] me_threshold,
  input  logic             me_ack,
  input  logic [SAD_W-1:0] me_min_sad,
  input  logic [MV_W-1:0]  me_min_mvec,
  output logic [BLK_W-1:0] blk_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SAD_W-1:0] res_sad,
  output logic [MV_W-1:0]  res_mvec,
  output logic [BLK_W-1:0] res_blk,
  output logic [SAD_W-1:0] best_sad,
  output logic [BLK_W-1:0] best_blk,
  output logic             busy,
  output logic             done,
  output logic             err
);

  me_sched_state_t state, next_state;
  logic capture, abort_take, tmo_hit, expired, aborted, last_blk;

  assign last_blk = (blk_idx == BLK_W'(NUM_BLOCKS - 1));

  me_sched_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (next_state != state),
    .en      ((state == ST_REQ) || (state == ST_RELEASE)),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    abort_take = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_REQ;
      ST_REQ: begin
        if (abort) begin
          next_state = ST_RELEASE;
          abort_take = 1'b1;
        end else if (me_ack) begin
          next_state = ST_RESULT;
          capture    = 1'b1;
        end else if (expired) begin
          next_state = ST_DONE;
          tmo_hit    = 1'b1;
        end
      end
      ST_RESULT: begin
        if (abort) begin
          next_state = ST_RELEASE;
          abort_take = 1'b1;
        end else if (res_ready) begin
          next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!me_ack) begin
          next_state = (aborted || abort || last_blk) ? ST_DONE : ST_REQ;
        end else if (expired) begin
          next_state = ST_DONE;
          tmo_hit    = 1'b1;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from next_state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      me_req       <= 1'b0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      aborted      <= 1'b0;
      me_threshold <= '0;
      blk_idx      <= '0;
      res_sad      <= '0;
      res_mvec     <= '0;
      res_blk      <= '0;
      best_sad     <= '1;
      best_blk     <= '0;
    end else begin
      me_req    <= (next_state == ST_REQ) || (next_state == ST_RESULT);
      res_valid <= (next_state == ST_RESULT);
      busy      <= (next_state != ST_IDLE);
      done      <= (next_state == ST_DONE);

      if ((state == ST_IDLE) && start) begin
        me_threshold <= threshold;
        blk_idx      <= '0;
        best_sad     <= '1;
        best_blk     <= '0;
        err          <= 1'b0;
        aborted      <= 1'b0;
      end

      if (capture) begin
        res_sad  <= me_min_sad;
        res_mvec <= me_min_mvec;
        res_blk  <= blk_idx;
        // Strict compare: on a tie the earlier block keeps the title.
        if (me_min_sad < best_sad) begin
          best_sad <= me_min_sad;
          best_blk <= blk_idx;
        end
      end

      if (abort_take) aborted <= 1'b1;
      if (tmo_hit)    err     <= 1'b1;

      if ((state == ST_RELEASE) && (next_state == ST_REQ)) begin
        blk_idx <= blk_idx + BLK_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_me_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_me_sched : self-checking bench with a behavioural core model      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_me_sched;
  import me_pkg::*;

  localparam int TBL   = 16;
  localparam int SWL   = 64;
  localparam int PEW   = 8;
  localparam int NB    = 4;
  localparam int TMO   = 120;
  localparam int SAD_W = sad_w(TBL, PEW);
  localparam int MV_W  = mv_w(SWL, TBL);
  localparam int BLK_W = blk_w(NB);

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [SAD_W-1:0] threshold, me_threshold, me_min_sad, res_sad, best_sad;
  logic [MV_W-1:0]  me_min_mvec, res_mvec;
  logic [BLK_W-1:0] blk_idx, res_blk, best_blk;
  logic             me_req, me_ack, res_valid, res_ready, busy, done, err;

  logic ready_val = 1'b1, rand_ready = 1'b0, rnd_bit = 1'b0;
  assign res_ready = rand_ready ? rnd_bit : ready_val;

  me_sched #(
    .TB_LENGTH(TBL), .SW_LENGTH(SWL), .PE_OUT_WIDTH(PEW),
    .NUM_BLOCKS(NB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .threshold(threshold),
    .me_req(me_req), .me_threshold(me_threshold), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .blk_idx(blk_idx),
    .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad),
    .res_mvec(res_mvec), .res_blk(res_blk), .best_sad(best_sad),
    .best_blk(best_blk), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural core: acks ack_lat cycles after req, drops ack fall_lat after req falls.
  int ack_lat = 100, fall_lat = 0;
  bit no_ack = 1'b0;
  logic [SAD_W-1:0] sad_tbl [NB];
  logic [MV_W-1:0]  mv_tbl  [NB];

  initial begin
    int req_cnt, fall_cnt;
    me_ack = 1'b0; me_min_sad = '0; me_min_mvec = '0;
    req_cnt = 0; fall_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (!me_req) begin
        req_cnt = 0;
        if (me_ack) begin
          if (fall_cnt >= fall_lat) me_ack = 1'b0;
          else fall_cnt++;
        end
      end else begin
        fall_cnt = 0;
        if (!me_ack && !no_ack) begin
          req_cnt++;
          if (req_cnt >= ack_lat) begin
            me_ack      = 1'b1;
            me_min_sad  = sad_tbl[blk_idx];
            me_min_mvec = mv_tbl[blk_idx];
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  mv;
    logic [BLK_W-1:0] blk;
  } res_t;
  res_t got[$];
  int done_cnt = 0;
  logic [SAD_W-1:0] done_best_sad;
  logic [BLK_W-1:0] done_best_blk;

  initial forever begin
    @(negedge clk);
    if (res_valid && res_ready) got.push_back('{res_sad, res_mvec, res_blk});
    if (done) done_cnt++;
  end

  typedef struct {
    logic [NB-1:0][SAD_W-1:0] s;
    logic [SAD_W-1:0]         eb;
    logic [BLK_W-1:0]         ebk;
    int                       lat;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int eb, input int ebk, input int lat);
    vec_t v;
    v.s[0] = SAD_W'(a); v.s[1] = SAD_W'(b); v.s[2] = SAD_W'(c); v.s[3] = SAD_W'(d);
    v.eb = SAD_W'(eb); v.ebk = BLK_W'(ebk); v.lat = lat;
    return v;
  endfunction

  function automatic void ref_best(output logic [SAD_W-1:0] bs, output logic [BLK_W-1:0] bb);
    bs = '1; bb = '0;
    for (int i = 0; i < NB; i++) begin
      if (sad_tbl[i] < bs) begin
        bs = sad_tbl[i];
        bb = BLK_W'(i);
      end
    end
  endfunction

  task automatic start_run(input logic [SAD_W-1:0] thr);
    int n;
    n = 0;
    while ((busy || me_ack) && n < 500) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    start = 1'b1; threshold = thr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_best_sad = best_sad;
        done_best_blk = best_blk;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  task automatic check_results(input string tag, input int exp_n);
    chk({tag, "_result_count"}, got.size(), exp_n);
    for (int i = 0; i < exp_n && i < got.size(); i++) begin
      chk($sformatf("%s_sad_%0d", tag, i), got[i].sad, sad_tbl[i]);
      chk($sformatf("%s_mvec_%0d", tag, i), got[i].mv, mv_tbl[i]);
      chk($sformatf("%s_blk_%0d", tag, i), got[i].blk, i);
    end
  endtask

  task automatic full_run(input string tag, input logic [SAD_W-1:0] thr,
                          input logic [SAD_W-1:0] eb, input logic [BLK_W-1:0] ebk);
    got.delete(); done_cnt = 0;
    start_run(thr);
    wait_done(tag, 3000);
    repeat (2) @(negedge clk);
    check_results(tag, NB);
    chk({tag, "_best_sad"}, done_best_sad, eb);
    chk({tag, "_best_blk"}, done_best_blk, ebk);
    chk({tag, "_threshold"}, me_threshold, thr);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  vec_t vtab[6];

  initial begin
    logic [SAD_W-1:0] bs, s0;
    logic [MV_W-1:0]  m0;
    logic [BLK_W-1:0] bb, k0;
    int n, bad;

    vtab[0] = mk(500, 300, 300, 900, 300, 1, 100);
    vtab[1] = mk(100, 100, 100, 100, 100, 0, 5);
    vtab[2] = mk(9, 8, 7, 6, 6, 3, 3);
    vtab[3] = mk(65535, 65535, 65535, 65535, 65535, 0, 2);
    vtab[4] = mk(0, 5, 0, 5, 0, 0, 1);
    vtab[5] = mk(7, 3, 65534, 3, 3, 1, 4);
    for (int i = 0; i < NB; i++) begin
      sad_tbl[i] = '0;
      mv_tbl[i]  = MV_W'(100 * i + 17);
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; threshold = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_me_req", me_req, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_blk_idx", blk_idx, 0);
    chk("rst_best_sad", best_sad, {SAD_W{1'b1}});
    chk("rst_best_blk", best_blk, 0);
    chk("rst_threshold", me_threshold, 0);

    // Directed table of SAD patterns with hand-computed best.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NB; i++) sad_tbl[i] = vtab[v].s[i];
      ack_lat = vtab[v].lat; fall_lat = v % 3;
      full_run($sformatf("tbl%0d", v), SAD_W'(1000 + v), vtab[v].eb, vtab[v].ebk);
    end

    // Backpressure on block 2 for 20 cycles.
    ack_lat = 10; fall_lat = 2; ready_val = 1'b0;
    got.delete(); done_cnt = 0;
    start_run(SAD_W'(77));
    bad = 0;
    for (int b = 0; b < NB; b++) begin
      n = 0;
      while (!res_valid && n < 2000) begin @(posedge clk); #1; n++; end
      chk($sformatf("bp_valid_%0d", b), res_valid, 1);
      if (b == 2) begin
        s0 = res_sad; m0 = res_mvec; k0 = res_blk;
        repeat (20) begin
          @(posedge clk); #1;
          if (!res_valid || res_sad !== s0 || res_mvec !== m0 || res_blk !== k0 || !me_req) bad++;
        end
      end
      ready_val = 1'b1;
      @(posedge clk); #1;
      ready_val = 1'b0;
    end
    chk("bp_unstable_cycles", bad, 0);
    wait_done("bp", 500);
    repeat (2) @(negedge clk);
    check_results("bp", NB);
    chk("bp_done_count", done_cnt, 1);
    ready_val = 1'b1;

    // Abort during REQ of block 1.
    ack_lat = 100; fall_lat = 1;
    sad_tbl[0] = 50; sad_tbl[1] = 40; sad_tbl[2] = 30; sad_tbl[3] = 20;
    got.delete(); done_cnt = 0;
    start_run(SAD_W'(5));
    n = 0;
    while (!(blk_idx == 1 && me_req && !res_valid) && n < 1000) begin @(posedge clk); #1; n++; end
    chk("abort_reached_blk1", blk_idx, 1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_falls", me_req, 0);
    abort = 1'b0;
    wait_done("abort", 500);
    repeat (2) @(negedge clk);
    check_results("abort", 1);
    chk("abort_blk_idx", blk_idx, 1);
    chk("abort_done_count", done_cnt, 1);
    chk("abort_err", err, 0);

    // Core never acks: timeout.
    no_ack = 1'b1;
    got.delete(); done_cnt = 0;
    start_run(SAD_W'(9));
    n = 0;
    while (!me_req && n < 20) begin @(posedge clk); #1; n++; end
    n = 0;
    while (me_req && n < TMO + 50) begin n++; @(posedge clk); #1; end
    chk("tmo_req_width", n, TMO);
    repeat (3) @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_done_count", done_cnt, 1);
    chk("tmo_results", got.size(), 0);
    chk("tmo_busy", busy, 0);
    no_ack = 1'b0;

    // Reset while a result is pending.
    ack_lat = 8; fall_lat = 0; ready_val = 1'b0;
    start_run(SAD_W'(11));
    n = 0;
    while (!res_valid && n < 500) begin @(posedge clk); #1; n++; end
    chk("rstmid_in_result", res_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_me_req", me_req, 0);
    chk("rstmid_res_valid", res_valid, 0);
    chk("rstmid_busy", busy, 0);
    rst = 1'b0; ready_val = 1'b1;
    repeat (4) @(posedge clk);
    ref_best(bs, bb);
    full_run("after_rst", SAD_W'(12), bs, bb);

    // Start pulsed while busy is ignored.
    ack_lat = 20;
    got.delete(); done_cnt = 0;
    start_run(SAD_W'(321));
    repeat (30) @(posedge clk);
    #1 start = 1'b1; threshold = SAD_W'(999);
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start", 1000);
    repeat (5) @(negedge clk);
    check_results("busy_start", NB);
    chk("busy_start_threshold", me_threshold, 321);
    chk("busy_start_done_count", done_cnt, 1);
    chk("busy_start_idle", busy, 0);

    // Randomized runs against the reference model, with random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NB; i++) begin
        sad_tbl[i] = ($urandom_range(0, 7) == 0) ? '1 : SAD_W'($urandom_range(0, 15));
        mv_tbl[i]  = MV_W'($urandom);
      end
      ack_lat = $urandom_range(1, 30); fall_lat = $urandom_range(0, 5);
      ref_best(bs, bb);
      full_run($sformatf("rnd%0d", r), SAD_W'($urandom), bs, bb);
    end
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
